// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and defaults for the stopwatch time base
package stopwatch_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  typedef logic [3:0] digit_t;

  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;

endpackage

// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control strobes in, BCD digits and blanking out
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic   tick_1hz;
  logic   tick_2hz;
  logic   tick_blink;
  logic   pause_pulse;
  logic   adj;
  logic   sel;
  digit_t seconds1;
  digit_t seconds2;
  digit_t minutes1;
  digit_t minutes2;
  logic   blank_sec;
  logic   blank_min;

  modport master (
    output tick_1hz, tick_2hz, tick_blink, pause_pulse, adj, sel,
    input  seconds1, seconds2, minutes1, minutes2, blank_sec, blank_min
  );

  modport slave (
    input  tick_1hz, tick_2hz, tick_blink, pause_pulse, adj, sel,
    output seconds1, seconds2, minutes1, minutes2, blank_sec, blank_min
  );

endinterface

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter wrapping from MAX to 00
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  output digit_t tens,
  output digit_t ones,
  output logic   wrap
);

  localparam digit_t MAX_TENS = digit_t'(MAX / 10);
  localparam digit_t MAX_ONES = digit_t'(MAX % 10);

  logic at_max;

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  // wrap is combinational so the caller can carry on the same edge
  assign wrap   = inc && at_max;

  // Advance the BCD pair on inc: wrap at MAX, otherwise ones 9->0 carries into tens
  always_ff @(posedge clk) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS stopwatch with run/pause, adjust and blanking
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  bus
);

  state_t state_q;
  state_t state_d;
  logic   running;
  logic   sec_inc;
  logic   min_inc;
  logic   sec_wrap;
  logic   min_wrap;
  logic   phase_q;
  logic   phase_d;
  logic   blank_sec_q;
  logic   blank_min_q;
  digit_t sec_tens;
  digit_t sec_ones;
  digit_t min_tens;
  digit_t min_ones;

  // Pause state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: each pause pulse flips RUN/PAUSED, independent of adjust mode
  always_comb begin
    state_d = state_q;
    if (bus.pause_pulse) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // Ticks are qualified by the current (pre-toggle) state, so a tick that
  // coincides with a pause pulse follows the state it arrived in.
  assign running = (state_q == ST_RUN);

  // Run mode counts seconds at 1 Hz with carry; adjust mode steps the selected
  // field at 2 Hz and the seconds wrap is kept away from the minutes.
  assign sec_inc = running &&
                   ((!bus.adj && bus.tick_1hz) ||
                    ( bus.adj && bus.sel && bus.tick_2hz));
  assign min_inc = running &&
                   ((!bus.adj && sec_wrap) ||
                    ( bus.adj && !bus.sel && bus.tick_2hz));

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_inc),
    .tens (sec_tens),
    .ones (sec_ones),
    .wrap (sec_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .tens (min_tens),
    .ones (min_ones),
    .wrap (min_wrap)
  );

  // Blink phase only runs in adjust mode and parks at 0 otherwise
  always_comb begin
    phase_d = phase_q;
    if (!bus.adj) begin
      phase_d = 1'b0;
    end else if (bus.tick_blink) begin
      phase_d = !phase_q;
    end
  end

  // Phase and blank registers; blanks use the next phase so they move with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q     <= 1'b0;
      blank_sec_q <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      blank_sec_q <= bus.adj &&  bus.sel && phase_d;
      blank_min_q <= bus.adj && !bus.sel && phase_d;
    end
  end

  assign bus.seconds1  = sec_ones;
  assign bus.seconds2  = sec_tens;
  assign bus.minutes1  = min_ones;
  assign bus.minutes2  = min_tens;
  assign bus.blank_sec = blank_sec_q;
  assign bus.blank_min = blank_min_q;

  // Minutes wrap silently; the wrap flag is only consumed for seconds
  logic unused_min_wrap;
  assign unused_min_wrap = min_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - scoreboard bench for stopwatch_counter
module tb_stopwatch_counter;

  typedef struct {
    logic [17:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  stopwatch_counter_if sw_if ();

  stopwatch_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = !clk;

  // Monitor: every expectation pushed since the last edge is compared here
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [17:0] got;
      e   = sb.pop_front();
      got = {sw_if.minutes2, sw_if.minutes1, sw_if.seconds2, sw_if.seconds1,
             sw_if.blank_min, sw_if.blank_sec};
      total++;
      if (got !== e.val) begin
        bad++;
        $display("FAIL %s: got mm:ss=%h%h:%h%h bmin=%b bsec=%b, expected %h%h:%h%h bmin=%b bsec=%b",
                 e.name, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                 e.val[17:14], e.val[13:10], e.val[9:6], e.val[5:2], e.val[1], e.val[0]);
      end
    end
  end

  task automatic cyc(input logic t1, input logic t2, input logic tb, input logic pp);
    sw_if.tick_1hz    = t1;
    sw_if.tick_2hz    = t2;
    sw_if.tick_blink  = tb;
    sw_if.pause_pulse = pp;
    @(posedge clk);
    #1;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.tick_blink  = 1'b0;
    sw_if.pause_pulse = 1'b0;
  endtask

  task automatic expect_out(input logic [3:0] m2, input logic [3:0] m1,
                            input logic [3:0] s2, input logic [3:0] s1,
                            input logic bm, input logic bs, input string name);
    exp_t e;
    e.val  = {m2, m1, s2, s1, bm, bs};
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    sw_if.adj         = 1'b0;
    sw_if.sel         = 1'b0;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.tick_blink  = 1'b0;
    sw_if.pause_pulse = 1'b0;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 0, 0, "reset");
    rst = 1'b1;

    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 10) expect_out(0, 0, 1, 0, 0, 0, "run_10");
      if (i == 59) expect_out(0, 0, 5, 9, 0, 0, "run_59");
      if (i == 60) expect_out(0, 1, 0, 0, 0, 0, "run_60_carry");
    end
    cyc(0, 1, 0, 0);
    expect_out(0, 1, 0, 0, 0, 0, "run_2hz_ignored");

    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    repeat (58) cyc(0, 1, 0, 0);
    expect_out(5, 9, 0, 0, 0, 0, "adj_min_59");
    sw_if.sel = 1'b1;
    repeat (58) cyc(0, 1, 0, 0);
    expect_out(5, 9, 5, 8, 0, 0, "adj_sec_58");
    sw_if.adj = 1'b0;
    cyc(1, 0, 0, 0);
    expect_out(5, 9, 5, 9, 0, 0, "run_5959");
    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 0, 0, 0, "wrap_all");

    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "run_0001");
    cyc(0, 0, 0, 1);
    expect_out(0, 0, 0, 1, 0, 0, "pause_enter");
    repeat (5) cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "paused_5_ticks");
    cyc(1, 0, 0, 1);
    expect_out(0, 0, 0, 1, 0, 0, "resume_tick_ignored");
    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 2, 0, 0, "resume_counts");
    cyc(1, 0, 0, 1);
    expect_out(0, 0, 0, 3, 0, 0, "pause_tick_counts");
    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 3, 0, 0, "paused_again");
    cyc(0, 0, 0, 1);

    sw_if.adj = 1'b1;
    sw_if.sel = 1'b1;
    repeat (55) cyc(0, 1, 0, 0);
    expect_out(0, 0, 5, 8, 0, 0, "adj_sec_0058");
    cyc(0, 1, 0, 0);
    expect_out(0, 0, 5, 9, 0, 0, "adj_sec_0059");
    cyc(0, 1, 0, 0);
    expect_out(0, 0, 0, 0, 0, 0, "adj_sec_wrap_no_carry");
    cyc(0, 1, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "adj_sec_0001");
    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "adj_1hz_ignored");
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "adj_paused_hold");
    cyc(0, 0, 0, 1);

    sw_if.sel = 1'b0;
    cyc(0, 0, 1, 0);
    expect_out(0, 0, 0, 1, 1, 0, "blink_1");
    cyc(0, 0, 1, 0);
    expect_out(0, 0, 0, 1, 0, 0, "blink_2");
    cyc(0, 0, 1, 0);
    expect_out(0, 0, 0, 1, 1, 0, "blink_3");
    sw_if.sel = 1'b1;
    cyc(0, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 1, "blank_sec_sel");
    sw_if.adj = 1'b0;
    cyc(0, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "blank_off");

    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    repeat (12) cyc(0, 1, 0, 0);
    sw_if.sel = 1'b1;
    repeat (33) cyc(0, 1, 0, 0);
    expect_out(1, 2, 3, 4, 0, 0, "preload_1234");
    cyc(0, 0, 1, 0);
    expect_out(1, 2, 3, 4, 0, 1, "blank_before_reset");
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    cyc(1, 1, 1, 0);
    expect_out(0, 0, 0, 0, 0, 0, "reset_mid");
    rst = 1'b1;
    sw_if.adj = 1'b0;
    cyc(1, 0, 0, 0);
    expect_out(0, 0, 0, 1, 0, 0, "post_reset_run");

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
